// File: rtl/lab3_mem_pkg.sv
// Shared definitions for the lab3 memory responder: message layouts, type codes and FSM states.
package lab3_mem_pkg;

  localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
  localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;
  localparam logic [2:0] MEM_TYPE_INIT  = 3'd2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [2:0]   msg_type;
    logic [7:0]   opaque;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_req_16b_t;

  typedef struct packed {
    logic [2:0]   msg_type;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_resp_16b_t;

  // Unknown type codes fall back to a read, so only WRITE and INIT store.
  function automatic logic is_store(input logic [2:0] msg_type);
    return (msg_type == MEM_TYPE_WRITE) || (msg_type == MEM_TYPE_INIT);
  endfunction

endpackage

// File: rtl/lab3_mem_refill_mem_responder_sram.sv
// Single-port line store: combinational read, synchronous write with per-byte enables.
module lab3_mem_refill_mem_responder_sram #(
  parameter int p_data_nbits  = 128,
  parameter int p_num_entries = 64,
  localparam int IDX_W = $clog2(p_num_entries)
) (
  input  logic                      clk,
  input  logic [IDX_W-1:0]          idx,
  input  logic                      wen,
  input  logic [p_data_nbits/8-1:0] wben,
  input  logic [p_data_nbits-1:0]   wdata,
  output logic [p_data_nbits-1:0]   rdata
);

  logic [p_data_nbits-1:0] mem [p_num_entries];

  assign rdata = mem[idx];

  // NOTE: storage arrays carry no reset; clearing them would need a sequencer
  // and contents are defined only after an INIT/WRITE.
  always_ff @(posedge clk) begin
    if (wen) begin
      for (int b = 0; b < p_data_nbits / 8; b++) begin
        if (wben[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/lab3_mem_refill_mem_responder.sv
// Memory-side responder for the 16B refill/evict port; one request in flight, fixed extra latency.
// Optional macro LAB3_MEM_ALIGN_CHECK_EN rejects requests whose addr[3:0] is non-zero.
module lab3_mem_refill_mem_responder
  import lab3_mem_pkg::*;
#(
  parameter int p_num_lines = 64,
  parameter int p_latency   = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memreq_val,
  output logic         memreq_rdy,
  input  logic [174:0] memreq_msg,
  output logic         memresp_val,
  input  logic         memresp_rdy,
  output logic [144:0] memresp_msg
);

  localparam int IDX_W = $clog2(p_num_lines);

  mem_req_16b_t  req;
  mem_resp_16b_t resp;
  assign req = memreq_msg;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       armed;

  logic [2:0]       lat_type;
  logic [7:0]       lat_opaque;
  logic [IDX_W-1:0] lat_idx;
  logic [127:0]     lat_data;
  logic             lat_misalign;
  logic             misalign_in;

  logic [127:0] resp_data;
  logic [1:0]   resp_test;
  logic [127:0] sram_rdata;
  logic         accept;
  logic         do_access;
  logic         sram_wen;

`ifdef LAB3_MEM_ALIGN_CHECK_EN
  assign misalign_in = |req.addr[3:0];
  logic unused_req_bits;
  assign unused_req_bits = ^{req.addr[31:4+IDX_W], req.len};
`else
  assign misalign_in = 1'b0;
  logic unused_req_bits;
  assign unused_req_bits = ^{req.addr[31:4+IDX_W], req.addr[3:0], req.len};
`endif

  // armed holds off acceptance until the first edge after reset releases,
  // so memreq_rdy comes purely from flops.
  assign memreq_rdy  = (state == IDLE) && armed;
  assign memresp_val = (state == RESP);
  assign accept      = memreq_val && memreq_rdy;
  assign do_access   = (state == WAIT) && (cnt == 4'd0);
  assign sram_wen    = do_access && is_store(lat_type) && !lat_misalign;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      armed <= 1'b1;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch forms.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: if (accept) begin
        state_nxt = WAIT;
        cnt_nxt   = 4'(p_latency);
      end
      WAIT: if (cnt == 4'd0) state_nxt = RESP;
            else             cnt_nxt   = cnt - 4'd1;
      RESP: if (memresp_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_type     <= '0;
      lat_opaque   <= '0;
      lat_idx      <= '0;
      lat_data     <= '0;
      lat_misalign <= 1'b0;
    end else if (accept) begin
      lat_type     <= req.msg_type;
      lat_opaque   <= req.opaque;
      lat_idx      <= req.addr[3+IDX_W:4];
      lat_data     <= req.data;
      lat_misalign <= misalign_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_data <= '0;
      resp_test <= 2'b00;
    end else if (do_access) begin
      resp_test <= lat_misalign ? 2'b11 : 2'b00;
      resp_data <= (lat_misalign || is_store(lat_type)) ? '0 : sram_rdata;
    end
  end

  lab3_mem_refill_mem_responder_sram #(
    .p_data_nbits (128),
    .p_num_entries(p_num_lines)
  ) u_sram (
    .clk  (clk),
    .idx  (lat_idx),
    .wen  (sram_wen),
    .wben ('1),
    .wdata(lat_data),
    .rdata(sram_rdata)
  );

  always_comb begin
    resp          = '0;
    resp.msg_type = lat_type;
    resp.opaque   = lat_opaque;
    resp.test     = resp_test;
    resp.len      = 4'd0;
    resp.data     = resp_data;
  end
  assign memresp_msg = resp;

endmodule

// File: tb/tb_lab3_mem_refill_mem_responder.sv
// Directed bench for lab3_mem_refill_mem_responder (p_num_lines=64, p_latency=2).
module tb_lab3_mem_refill_mem_responder;
  import lab3_mem_pkg::*;

  localparam logic [127:0] D0 = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [127:0] DA = 128'haaaaaaaa_11111111_aaaaaaaa_11111111;
  localparam logic [127:0] DB = 128'hbbbbbbbb_22222222_bbbbbbbb_22222222;
  localparam logic [127:0] DC = 128'hcccccccc_33333333_cccccccc_33333333;
  localparam logic [127:0] DD = 128'hdddddddd_44444444_dddddddd_44444444;
  localparam logic [127:0] DE = 128'heeeeeeee_55555555_eeeeeeee_55555555;
  localparam int EXP_LAT = 4;  // p_latency + 2

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         memreq_val = 1'b0;
  logic         memreq_rdy;
  logic [174:0] memreq_msg = '0;
  logic         memresp_val;
  logic         memresp_rdy = 1'b0;
  logic [144:0] memresp_msg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lab3_mem_refill_mem_responder #(.p_num_lines(64), .p_latency(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .memreq_val (memreq_val),
    .memreq_rdy (memreq_rdy),
    .memreq_msg (memreq_msg),
    .memresp_val(memresp_val),
    .memresp_rdy(memresp_rdy),
    .memresp_msg(memresp_msg)
  );

  function automatic logic [174:0] mk_req(input logic [2:0] t, input logic [7:0] op,
                                          input logic [31:0] addr, input logic [127:0] d);
    mem_req_16b_t r;
    r.msg_type = t; r.opaque = op; r.addr = addr; r.len = 4'd0; r.data = d;
    return r;
  endfunction

  // Issue one request, wait for its response, complete the handshake.
  task automatic xact(input logic [2:0] t, input logic [7:0] op, input logic [31:0] addr,
                      input logic [127:0] d, output mem_resp_16b_t resp, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!memreq_rdy && n < 50) begin @(negedge clk); n++; end
    memreq_val = 1'b1;
    memreq_msg = mk_req(t, op, addr, d);
    @(negedge clk);
    memreq_val = 1'b0;
    lat = 1;
    while (!memresp_val && lat < 50) begin @(negedge clk); lat++; end
    resp = memresp_msg;
    total++;
    if (!memresp_val) begin
      bad++;
      $display("FAIL xact_timeout addr=%h: no response after %0d cycles", addr, lat);
    end
    memresp_rdy = 1'b1;
    @(negedge clk);
    memresp_rdy = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (memreq_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b exp=0", memreq_rdy); end
    total++;
    if (memresp_val !== 1'b0) begin bad++; $display("FAIL reset_val got=%b exp=0", memresp_val); end
    total++;
    if (memresp_msg !== '0) begin bad++; $display("FAIL reset_msg got=%h exp=0", memresp_msg); end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (memreq_rdy !== 1'b1) begin bad++; $display("FAIL post_reset_rdy got=%b exp=1", memreq_rdy); end
  endtask

  task automatic test_init_read;
    mem_resp_16b_t r;
    int lat;
    xact(MEM_TYPE_INIT, 8'h01, 32'h100, D0, r, lat);
    total++;
    if (r !== {MEM_TYPE_INIT, 8'h01, 2'b00, 4'd0, 128'd0}) begin
      bad++; $display("FAIL init_resp got=%h exp type=2 opaque=01 data=0", r);
    end
    total++;
    if (lat !== EXP_LAT) begin bad++; $display("FAIL init_latency got=%0d exp=%0d", lat, EXP_LAT); end
    xact(MEM_TYPE_READ, 8'h05, 32'h100, '0, r, lat);
    total++;
    if (r !== {MEM_TYPE_READ, 8'h05, 2'b00, 4'd0, D0}) begin
      bad++; $display("FAIL read_resp got=%h exp data=%h", r, D0);
    end
  endtask

  task automatic test_latency;
    int n;
    n = 0;
    @(negedge clk);
    while (!memreq_rdy && n < 50) begin @(negedge clk); n++; end
    memreq_val = 1'b1;
    memreq_msg = mk_req(MEM_TYPE_READ, 8'h07, 32'h100, '0);
    @(negedge clk);
    memreq_val = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      total++;
      if (memreq_rdy !== 1'b0 || memresp_val !== (k == 4)) begin
        bad++;
        $display("FAIL latency_cycle_%0d got rdy=%b val=%b exp rdy=0 val=%b", k, memreq_rdy,
                 memresp_val, k == 4);
      end
      if (k < 4) @(negedge clk);
    end
    memresp_rdy = 1'b1;
    @(negedge clk);
    memresp_rdy = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [144:0] snap;
    int n;
    n = 0;
    @(negedge clk);
    while (!memreq_rdy && n < 50) begin @(negedge clk); n++; end
    memreq_val = 1'b1;
    memreq_msg = mk_req(MEM_TYPE_READ, 8'h33, 32'h100, '0);
    @(negedge clk);
    memreq_val = 1'b0;
    n = 0;
    while (!memresp_val && n < 50) begin @(negedge clk); n++; end
    snap = memresp_msg;
    total++;
    if (snap !== {MEM_TYPE_READ, 8'h33, 2'b00, 4'd0, D0}) begin
      bad++; $display("FAIL bp_msg got=%h exp data=%h", snap, D0);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (memresp_val !== 1'b1 || memresp_msg !== snap || memreq_rdy !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold_%0d got val=%b rdy=%b msg=%h", i, memresp_val, memreq_rdy, memresp_msg);
      end
      @(negedge clk);
    end
    memresp_rdy = 1'b1;
    @(negedge clk);
    memresp_rdy = 1'b0;
    total++;
    if (memreq_rdy !== 1'b1 || memresp_val !== 1'b0) begin
      bad++; $display("FAIL bp_release got rdy=%b val=%b exp rdy=1 val=0", memreq_rdy, memresp_val);
    end
  endtask

  task automatic test_alias;
    mem_resp_16b_t r;
    int lat;
    xact(MEM_TYPE_WRITE, 8'h10, 32'h2A0, DA, r, lat);
    total++;
    if (r !== {MEM_TYPE_WRITE, 8'h10, 2'b00, 4'd0, 128'd0}) begin
      bad++; $display("FAIL write_resp got=%h exp type=1 data=0", r);
    end
    xact(MEM_TYPE_READ, 8'h11, 32'h6A0, '0, r, lat);
    total++;
    if (r.data !== DA) begin bad++; $display("FAIL alias_read got=%h exp=%h", r.data, DA); end
    xact(MEM_TYPE_WRITE, 8'h12, 32'h2B0, DB, r, lat);
    xact(MEM_TYPE_READ, 8'h13, 32'h2A0, '0, r, lat);
    total++;
    if (r.data !== DA) begin bad++; $display("FAIL neighbour_read got=%h exp=%h", r.data, DA); end
    xact(MEM_TYPE_READ, 8'h14, 32'h2B0, '0, r, lat);
    total++;
    if (r.data !== DB) begin bad++; $display("FAIL second_line got=%h exp=%h", r.data, DB); end
  endtask

  task automatic test_unknown_type;
    mem_resp_16b_t r;
    int lat;
    xact(3'd5, 8'h5a, 32'h100, DE, r, lat);
    total++;
    if (r !== {3'd5, 8'h5a, 2'b00, 4'd0, D0}) begin
      bad++; $display("FAIL unknown_type got=%h exp type=5 data=%h", r, D0);
    end
  endtask

  task automatic test_reset_abort;
    mem_resp_16b_t r;
    int lat;
    int seen;
    xact(MEM_TYPE_INIT, 8'h20, 32'h300, DC, r, lat);
    @(negedge clk);
    memreq_val = 1'b1;
    memreq_msg = mk_req(MEM_TYPE_WRITE, 8'h21, 32'h300, DD);
    @(negedge clk);
    memreq_val = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (memresp_val !== 1'b0 || memreq_rdy !== 1'b0) begin
      bad++; $display("FAIL abort_in_reset got val=%b rdy=%b exp 0/0", memresp_val, memreq_rdy);
    end
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (memresp_val === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL abort_resp got=%0d responses exp=0", seen); end
    xact(MEM_TYPE_READ, 8'h22, 32'h300, '0, r, lat);
    total++;
    if (r.data !== DC) begin bad++; $display("FAIL abort_dropped got=%h exp=%h", r.data, DC); end
  endtask

  task automatic test_align;
    mem_resp_16b_t r;
    int lat;
    xact(MEM_TYPE_WRITE, 8'h40, 32'h104, DE, r, lat);
`ifdef LAB3_MEM_ALIGN_CHECK_EN
    total++;
    if (r.test !== 2'b11 || r.data !== '0) begin
      bad++; $display("FAIL align_resp got test=%b data=%h exp test=11 data=0", r.test, r.data);
    end
    xact(MEM_TYPE_READ, 8'h41, 32'h100, '0, r, lat);
    total++;
    if (r.data !== D0) begin bad++; $display("FAIL align_untouched got=%h exp=%h", r.data, D0); end
`else
    total++;
    if (r.test !== 2'b00) begin bad++; $display("FAIL align_test got=%b exp=00", r.test); end
    xact(MEM_TYPE_READ, 8'h41, 32'h100, '0, r, lat);
    total++;
    if (r.data !== DE) begin bad++; $display("FAIL align_lands got=%h exp=%h", r.data, DE); end
`endif
    total++;
    if (lat !== EXP_LAT) begin bad++; $display("FAIL align_latency got=%0d exp=%0d", lat, EXP_LAT); end
  endtask

  initial begin
    test_reset();
    test_init_read();
    test_latency();
    test_backpressure();
    test_alias();
    test_unknown_type();
    test_reset_abort();
    test_align();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
